// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial_bit_source slice.
// Build option SERIAL_LSB_FIRST_EN selects LSB-first bit order in serial_bit_source.
package serial_pkg;

    typedef enum logic [0:0] {
        SER_IDLE,
        SER_SHIFT
    } ser_state_t;

    localparam int unsigned SER_WIDTH_DEF      = 8;
    localparam logic        SER_IDLE_LEVEL_DEF = 1'b0;

    // Bit counter width; never below one bit so a 2-bit word still gets a counter.
    function automatic int unsigned ser_cnt_bits(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_hold_reg.sv
// One-entry holding register with full flag and ready output.
// A write and a read on the same edge replace the entry and keep it full.
module serial_hold_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [Width-1:0] data_i,
    input  logic             rd_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             ready_o
);

    logic [Width-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (wr_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (rd_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o  = data_q;
    assign full_o  = full_q;
    // Reset gating keeps the source from handing over a word that would be discarded.
    assign ready_o = !full_q && rst_ni;

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source feeding the X stream of the sequence detector.
// Define SERIAL_LSB_FIRST_EN to send LSB first; default build sends MSB first.
module serial_bit_source
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH      = SER_WIDTH_DEF,
    parameter logic        IDLE_LEVEL = SER_IDLE_LEVEL_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             PAUSE,
    output logic             X,
    output logic             X_VALID,
    output logic             BUSY
);

    localparam int unsigned         CntW    = ser_cnt_bits(WIDTH);
    localparam logic [CntW-1:0]     LastCnt = CntW'(WIDTH - 1);

    ser_state_t       state_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_shifted;
    logic [CntW-1:0]  cnt_q;
    logic             x_q;
    logic             x_valid_q;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             hold_ready;
    logic             hold_wr;
    logic             hold_rd;

    logic             accept;
    logic             load_direct;
    logic             word_end;
    logic             out_bit;

`ifdef SERIAL_LSB_FIRST_EN
    assign out_bit    = sh_q[0];
    assign sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
`else
    assign out_bit    = sh_q[WIDTH-1];
    assign sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
`endif

    assign accept      = IN_VALID && hold_ready;
    assign load_direct = accept && (state_q == SER_IDLE) && !hold_full;
    assign hold_wr     = accept && !load_direct;
    assign word_end    = (state_q == SER_SHIFT) && !PAUSE && (cnt_q == LastCnt);
    // Held word moves to the shifter at a word boundary, or at once if the shifter is empty.
    assign hold_rd     = hold_full && (word_end || (state_q == SER_IDLE));

    serial_hold_reg #(
        .Width (WIDTH)
    ) u_hold (
        .clk_i   (CLK),
        .rst_ni  (CLR),
        .wr_i    (hold_wr),
        .data_i  (IN_DATA),
        .rd_i    (hold_rd),
        .data_o  (hold_data),
        .full_o  (hold_full),
        .ready_o (hold_ready)
    );

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q   <= SER_IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            x_q       <= IDLE_LEVEL;
            x_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                SER_IDLE: begin
                    x_q       <= IDLE_LEVEL;
                    x_valid_q <= 1'b0;
                    if (hold_rd) begin
                        sh_q    <= hold_data;
                        cnt_q   <= '0;
                        state_q <= SER_SHIFT;
                    end else if (load_direct) begin
                        sh_q    <= IN_DATA;
                        cnt_q   <= '0;
                        state_q <= SER_SHIFT;
                    end
                end
                SER_SHIFT: begin
                    if (PAUSE) begin
                        x_valid_q <= 1'b0;
                    end else begin
                        x_q       <= out_bit;
                        x_valid_q <= 1'b1;
                        if (word_end) begin
                            cnt_q <= '0;
                            if (hold_rd) begin
                                sh_q <= hold_data;
                            end else begin
                                sh_q    <= sh_shifted;
                                state_q <= SER_IDLE;
                            end
                        end else begin
                            sh_q  <= sh_shifted;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= SER_IDLE;
            endcase
        end
    end

    assign IN_READY = hold_ready;
    assign X        = x_q;
    assign X_VALID  = x_valid_q;
    assign BUSY     = (state_q == SER_SHIFT) || hold_full;

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parameterised parallel-to-serial stage that drives the single-bit `X` stream consumed by the downstream sequence-detector FSM. It accepts words over a valid/ready handshake and shifts them out one bit per `CLK`. A one-word holding register lets back-to-back words stream with no idle gap. It sits between the stimulus/word source and the detector and owns all bit ordering and idle filling of `X`.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `IDLE_LEVEL`, 1'b0: value driven on `X` whenever no bit is being sent.
- `CLK` input 1: sole clock; all state updates on the rising edge.
- `CLR` input 1: reset, synchronous, active-low.
- `IN_DATA` input WIDTH: parallel word to serialise.
- `IN_VALID` input 1: `IN_DATA` is valid.
- `IN_READY` output 1: holding register can accept a word this cycle.
- `PAUSE` input 1: freezes shifting while high.
- `X` output 1: serial bit to the detector; registered.
- `X_VALID` output 1: `X` carries a data bit this cycle; registered.
- `BUSY` output 1: shifter or holding register is occupied.

## Operation
- Storage:
  - shift register `sh[WIDTH-1:0]`
  - holding register `hold[WIDTH-1:0]` with flag `hold_full`
  - bit counter `cnt` of width `$clog2(WIDTH)`
  - FSM state
- FSM states:
  - IDLE: shifter empty.
  - SHIFT: a word is being sent.
- Accept: a word is accepted when `IN_VALID && IN_READY` at a rising edge.
  - If in IDLE with `hold_full`=0, the word goes straight into `sh`. `cnt`=0 and the FSM moves to SHIFT.
  - Otherwise the word goes into `hold` and `hold_full` is set.
- `IN_READY` = `!hold_full && CLR`. It is combinational from registered state and never depends on `IN_VALID`.
- SHIFT, with `PAUSE`=0, each edge:
  - `X` <= current bit (`sh[WIDTH-1]`, MSB first), `X_VALID` <= 1.
  - `sh` shifts left and `cnt` increments.
- End of word: when `cnt`==WIDTH-1 the last bit is emitted.
  - If `hold_full`, `hold` moves into `sh`, `hold_full` clears, `cnt`=0 and the FSM stays in SHIFT.
  - Otherwise the FSM moves to IDLE.
- Simultaneous transfer and accept: if a hold-to-shifter transfer and an accept occur on the same edge, the new word lands in `hold` and `hold_full` stays 1. No word is lost.
- IDLE: `X` <= `IDLE_LEVEL`, `X_VALID` <= 0.
- `PAUSE`=1 in SHIFT:
  - `sh`, `cnt` and `X` are held; `X_VALID` <= 0.
  - Accepts into `hold` still occur.
  - Shifting resumes on the first edge with `PAUSE`=0, with no bit lost or repeated.
- `PAUSE` in IDLE has no effect.
- `BUSY` = (state==SHIFT) || `hold_full`.

## Timing
- Reset: an edge with `CLR`=0 sets:
  - state IDLE, `hold_full`=0, `cnt`=0, `sh`=0
  - `X`=`IDLE_LEVEL`, `X_VALID`=0
  - `IN_READY` reads 0 while `CLR`=0, and 1 on the first cycle after release.
- Reset mid-word: the partial word and any held word are discarded. `X` returns to `IDLE_LEVEL` on the next edge and no trailing bits are emitted.
- Latency: a word accepted at edge E into an empty block has its first bit on `X` (with `X_VALID`=1) after edge E+1. Its last bit appears after edge E+WIDTH.
- Throughput: one bit per cycle sustained when a word is held before the current word ends. `X_VALID` then stays high across word boundaries.
- Ready timing: `IN_READY` falls the cycle after `hold` fills. It rises the cycle after `hold` transfers to `sh`.

## Configuration
- `SERIAL_LSB_FIRST_EN` defined: bits are sent LSB first (`sh[0]` emitted, right shift).
- Not defined: MSB first, as described above.
- Handshake, latency and all counts are identical in both builds.

## Structure
- Package `serial_pkg` holds:
  - the state enum `ser_state_t` {`SER_IDLE`, `SER_SHIFT`}
  - default constants `SER_WIDTH_DEF`=8 and `SER_IDLE_LEVEL_DEF`=1'b0
- Sub-module `serial_hold_reg` implements the one-entry holding register with its full flag and ready logic. The top level contains the FSM, shifter and counter.

## Test plan
- Single word 8'hA5 accepted at edge E, MSB build -> `X` = 1,0,1,0,0,1,0,1 after edges E+1..E+8 with `X_VALID`=1. Then `X`=0 and `X_VALID`=0.
- Words 8'hF0 and 8'h0F offered back to back -> 16 contiguous `X_VALID` cycles carrying 11110000 00001111. `IN_READY` low for exactly the cycles `hold` is full.
- `IN_VALID` held high with 3 words queued -> the third word is accepted only after the first transfer. No word is dropped or duplicated and `BUSY` stays 1 throughout.
- 8'hC3, `PAUSE` high for 3 cycles after the 4th bit -> `X` is held and `X_VALID`=0 for 3 cycles. Bits resume as 0,0,1,1 and the total valid bit count is 8.
- `CLR` low after the 5th bit of 8'hAA, with 8'h55 held -> on the next edge `X`=`IDLE_LEVEL`, `X_VALID`=0 and `BUSY`=0. No 8'h55 bits are ever emitted.
- `SERIAL_LSB_FIRST_EN` build, word 8'h01 -> `X` = 1,0,0,0,0,0,0,0.
